fclassgen: RTL and testbench
============================

# fclassgen

Sequential class-value generator for the FPU: the inverse of the classify path. It accepts a 10-bit class mask in the same bit layout that FCLASS produces, plus a format. It then emits one canonical, NaN-boxed operand per set mask bit, lowest bit first, over a valid/ready stream. It sits beside the FPU operand muxes and feeds built-in self-test and the verification bench. Every emitted value must classify back to exactly its own mask bit.

## Interface
Parameters:
- P — cvw_t configuration; uses P.FLEN, P.F_SUPPORTED, P.D_SUPPORTED, P.ZFH_SUPPORTED, P.Q_SUPPORTED.

Ports:
- clk  in  1  clock; the block uses one clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqMask  in  10  class mask; the bit order is fixed and listed under Operation.
- ReqFmt  in  2  operand format: 00 single, 01 double, 10 half, 11 quad.
- ReqErr  out  1  one-cycle pulse: the accepted request had an unsupported format.
- OutValid  out  1  output element valid.
- OutReady  in  1  consumer accepts the element.
- OutVal  out  FLEN  generated operand, NaN-boxed with ones above the format width.
- OutIdx  out  4  class index 0–9 of OutVal.
- OutLast  out  1  OutVal is the final element of the current request.
- Busy  out  1  state is not IDLE.

## Operation
- Mask bit order:
  - 0 −Inf
  - 1 −Norm
  - 2 −Subnorm
  - 3 −Zero
  - 4 +Zero
  - 5 +Subnorm
  - 6 +Norm
  - 7 +Inf
  - 8 sNaN
  - 9 qNaN
- FSM states: IDLE and EMIT.
- IDLE:
  - ReqReady=1.
  - On ReqValid, latch the mask into Pending[9:0] and latch Fmt.
  - If the format is unsupported: pulse ReqErr, clear Pending, stay in IDLE.
  - If Pending==0: stay in IDLE and emit nothing.
  - Otherwise go to EMIT.
- EMIT:
  - ReqReady=0.
  - OutIdx = index of the lowest set bit of Pending.
  - OutLast = 1 when Pending has exactly one bit set.
  - On OutValid&OutReady, clear that bit. If it was the last bit, go to IDLE; otherwise present the next element on the following cycle.
  - While OutReady=0, OutVal, OutIdx and OutLast hold stable.
- Canonical values, single (hex), in mask-bit order 0–9:
  - FF800000, BF800000, 80000001, 80000000, 00000000
  - 00000001, 3F800000, 7F800000, 7F800001, 7FC00000
- Other formats follow the same rule:
  - Norm: exponent = bias, fraction = 0 (±1.0).
  - Subnorm: fraction LSB only.
  - sNaN: all-ones exponent, fraction LSB only.
  - qNaN: all-ones exponent, fraction MSB only.
- Double example: −Norm is BFF0000000000000 and qNaN is 7FF8000000000000.
- Bits above the format width are forced to 1.

## Timing
- Reset values:
  - state IDLE, Pending 0;
  - ReqReady=1; OutValid, OutLast, ReqErr and Busy = 0;
  - OutVal=0, OutIdx=0.
- Latency: a request accepted in cycle N gives OutValid=1 in cycle N+1, and the first element is registered.
- Throughput: one element per cycle while OutReady=1. A request with k mask bits occupies EMIT for exactly k cycles under continuous ready.
- IDLE is always entered for at least one cycle between requests, so there is no request/output overlap.
- ReqErr asserts in cycle N+1 for exactly one cycle. OutValid stays 0.
- Reset mid-EMIT: the block returns to reset values immediately (asynchronous), and the partial stream is abandoned.
- OutValid is never dropped before its handshake.

## Structure
- The class-index constants (CLS_NINF=0 … CLS_QNAN=9) and the FmtSel encoding belong in the shared cvw package. The same constants are then used by the classifier and its checkers.
- Natural sub-module: fclassval, purely combinational, mapping (OutIdx, Fmt) to a FLEN NaN-boxed value. It is parameterised by P and instantiated once.
- The top level holds the FSM, the Pending register, the lowest-set-bit priority encoder and the output registers.

## Test plan
- Single format:
  - Stimulus: ReqMask=3FF, Fmt=00, OutReady=1.
  - Response: 10 elements on consecutive cycles, OutIdx 0..9, values in the single list above.
  - OutLast only on idx 9.
  - Each OutVal run through FCLASS returns 1<<OutIdx.
- Double, sparse mask with stalls:
  - Stimulus: ReqMask=0x242 (bits 1, 6, 9), Fmt=01, OutReady toggling 1,0,0,1,…
  - Response: BFF0000000000000, 3FF0000000000000, 7FF8000000000000, each held stable during stalls.
  - Upper bits are all ones when FLEN>64.
- Empty mask:
  - Stimulus: ReqMask=000.
  - Response: accepted, no OutValid, ReqReady=1 again on the next cycle.
- Unsupported format:
  - Stimulus: Fmt=11 with Q unsupported.
  - Response: ReqErr pulses for one cycle, no output, FSM stays in IDLE.
- Reset mid-stream:
  - Stimulus: assert reset after the 2nd of 5 elements.
  - Response: OutValid=0, Busy=0, ReqReady=1 at once; a new request then starts cleanly from its lowest bit.

Source files
------------

// File: rtl/fclassgen_pkg.sv
// Shared FPU class-generator definitions: configuration record, class indices,
// format encodings and small helpers used by the generator and its checkers.
package fclassgen_pkg;

  typedef struct packed {
    int   FLEN;
    logic F_SUPPORTED;
    logic D_SUPPORTED;
    logic ZFH_SUPPORTED;
    logic Q_SUPPORTED;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{FLEN: 64, F_SUPPORTED: 1'b1, D_SUPPORTED: 1'b1,
                                   ZFH_SUPPORTED: 1'b1, Q_SUPPORTED: 1'b0};

  localparam logic [3:0] CLS_NINF  = 4'd0;
  localparam logic [3:0] CLS_NNORM = 4'd1;
  localparam logic [3:0] CLS_NSUB  = 4'd2;
  localparam logic [3:0] CLS_NZERO = 4'd3;
  localparam logic [3:0] CLS_PZERO = 4'd4;
  localparam logic [3:0] CLS_PSUB  = 4'd5;
  localparam logic [3:0] CLS_PNORM = 4'd6;
  localparam logic [3:0] CLS_PINF  = 4'd7;
  localparam logic [3:0] CLS_SNAN  = 4'd8;
  localparam logic [3:0] CLS_QNAN  = 4'd9;

  localparam logic [1:0] FMT_S = 2'b00;
  localparam logic [1:0] FMT_D = 2'b01;
  localparam logic [1:0] FMT_H = 2'b10;
  localparam logic [1:0] FMT_Q = 2'b11;

  function automatic logic fmt_supported(input cvw_t p, input logic [1:0] fmt);
    case (fmt)
      FMT_S:   return p.F_SUPPORTED   && (p.FLEN >= 32);
      FMT_D:   return p.D_SUPPORTED   && (p.FLEN >= 64);
      FMT_H:   return p.ZFH_SUPPORTED && (p.FLEN >= 16);
      default: return p.Q_SUPPORTED   && (p.FLEN >= 128);
    endcase
  endfunction

  function automatic logic [3:0] lowest_set(input logic [9:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_single_bit(input logic [9:0] m);
    return (m != 10'd0) && ((m & (m - 10'd1)) == 10'd0);
  endfunction

endpackage

// File: rtl/fclassgen_val.sv
// Combinational map from (class index, format) to the canonical NaN-boxed
// operand of that class.
module fclassval
  import fclassgen_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic [3:0]        idx_i,
  input  logic [1:0]        fmt_i,
  output logic [P.FLEN-1:0] val_o
);

  localparam int W = P.FLEN;

  // Every field is built as a shifted mask so one function serves all formats;
  // a format as wide as FLEN yields an empty box because 1<<W wraps to 0.
  function automatic logic [W-1:0] canon(input logic [3:0] idx, input int ew, input int mw);
    logic [W-1:0] box, sgn, exp1, bias, fmsb, one;
    one  = W'(1);
    box  = ~((one << (ew + mw + 1)) - one);
    sgn  = one << (ew + mw);
    exp1 = ((one << ew) - one) << mw;
    bias = ((one << (ew - 1)) - one) << mw;
    fmsb = one << (mw - 1);
    case (idx)
      CLS_NINF:  return box | sgn | exp1;
      CLS_NNORM: return box | sgn | bias;
      CLS_NSUB:  return box | sgn | one;
      CLS_NZERO: return box | sgn;
      CLS_PZERO: return box;
      CLS_PSUB:  return box | one;
      CLS_PNORM: return box | bias;
      CLS_PINF:  return box | exp1;
      CLS_SNAN:  return box | exp1 | one;
      CLS_QNAN:  return box | exp1 | fmsb;
      default:   return '0;
    endcase
  endfunction

  always_comb begin
    val_o = '0;
    if (fmt_supported(P, fmt_i)) begin
      case (fmt_i)
        FMT_S:   val_o = canon(idx_i, 8, 23);
        FMT_D:   val_o = canon(idx_i, 11, 52);
        FMT_H:   val_o = canon(idx_i, 5, 10);
        default: val_o = canon(idx_i, 15, 112);
      endcase
    end
  end

endmodule

// File: rtl/fclassgen.sv
// Sequential class-value generator: turns a class mask into a stream of
// canonical operands, lowest class bit first, one per handshake.
module fclassgen
  import fclassgen_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [9:0]        ReqMask,
  input  logic [1:0]        ReqFmt,
  output logic              ReqErr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [P.FLEN-1:0] OutVal,
  output logic [3:0]        OutIdx,
  output logic              OutLast,
  output logic              Busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [9:0]        pending_q, pending_d;
  logic [1:0]        fmt_q, fmt_d;
  logic [3:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [P.FLEN-1:0] val_q, val_next;
  logic              load;
  logic [9:0]        remain;

  // The value is looked up for the element about to be presented, so the
  // output register always holds the operand matching idx_q.
  fclassval #(.P(P)) u_val (
    .idx_i(idx_d),
    .fmt_i(fmt_d),
    .val_o(val_next)
  );

  assign remain = pending_q & ~(10'd1 << idx_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    fmt_d     = fmt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    err_d     = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          if (!fmt_supported(P, ReqFmt)) begin
            err_d     = 1'b1;
            pending_d = '0;
          end else begin
            pending_d = ReqMask;
            fmt_d     = ReqFmt;
            if (ReqMask != 10'd0) begin
              state_d = EMIT;
              idx_d   = lowest_set(ReqMask);
              last_d  = is_single_bit(ReqMask);
              load    = 1'b1;
            end
          end
        end
      end
      default: begin
        if (OutReady) begin
          pending_d = remain;
          if (remain == 10'd0) begin
            state_d = IDLE;
          end else begin
            idx_d  = lowest_set(remain);
            last_d = is_single_bit(remain);
            load   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      fmt_q     <= FMT_S;
      idx_q     <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      val_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      fmt_q     <= fmt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      err_q     <= err_d;
      if (load) val_q <= val_next;
    end
  end

  assign ReqReady = (state_q == IDLE);
  assign OutValid = (state_q == EMIT);
  assign Busy     = (state_q != IDLE);
  assign ReqErr   = err_q;
  assign OutVal   = val_q;
  assign OutIdx   = idx_q;
  assign OutLast  = OutValid & last_q;

endmodule

// File: tb/tb_fclassgen.sv
// Directed bench for fclassgen with the default 64-bit FLEN configuration.
module tb_fclassgen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [9:0]  ReqMask = '0;
  logic [1:0]  ReqFmt = '0;
  logic        ReqErr;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [63:0] OutVal;
  logic [3:0]  OutIdx;
  logic        OutLast;
  logic        Busy;

  int checks = 0;
  int failures = 0;

  logic [63:0] ev [10];
  logic [3:0]  ei [10];

  fclassgen dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqMask(ReqMask), .ReqFmt(ReqFmt),
    .ReqErr(ReqErr), .OutValid(OutValid), .OutReady(OutReady), .OutVal(OutVal),
    .OutIdx(OutIdx), .OutLast(OutLast), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [9:0] mask, input logic [1:0] fmt);
    check("req_ready_before_send", 64'(ReqReady), 64'd1);
    ReqValid = 1'b1;
    ReqMask  = mask;
    ReqFmt   = fmt;
    @(negedge clk);
    ReqValid = 1'b0;
    $display("req mask=%h fmt=%0d", mask, fmt);
  endtask

  // stall=1 drives OutReady with the repeating pattern 1,0,0.
  task automatic stream(input int n, input int stall);
    int k = 0;
    for (int c = 0; c < 60 && k < n; c++) begin
      OutReady = (stall == 0) || (c % 3 == 0);
      check("out_valid", 64'(OutValid), 64'd1);
      check("out_idx", 64'(OutIdx), 64'(ei[k]));
      check("out_val", OutVal, ev[k]);
      check("out_last", 64'(OutLast), 64'(k == n - 1));
      $display("out idx=%0d val=%h last=%0d ready=%0d", OutIdx, OutVal, OutLast, OutReady);
      if (OutReady) k++;
      @(negedge clk);
    end
    check("stream_count", 64'(k), 64'(n));
    OutReady = 1'b1;
    check("idle_valid", 64'(OutValid), 64'd0);
    check("idle_ready", 64'(ReqReady), 64'd1);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 64'(ReqReady), 64'd1);
    check("rst_valid", 64'(OutValid), 64'd0);
    check("rst_last", 64'(OutLast), 64'd0);
    check("rst_err", 64'(ReqErr), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_val", OutVal, 64'd0);
    check("rst_idx", 64'(OutIdx), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single, full mask, continuous ready.
    ev = '{64'hFFFFFFFF_FF800000, 64'hFFFFFFFF_BF800000, 64'hFFFFFFFF_80000001,
           64'hFFFFFFFF_80000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000001,
           64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_7F800000, 64'hFFFFFFFF_7F800001,
           64'hFFFFFFFF_7FC00000};
    for (int i = 0; i < 10; i++) ei[i] = 4'(i);
    send(10'h3FF, 2'b00);
    stream(10, 0);

    // Double, sparse mask, stalled consumer.
    ev[0] = 64'hBFF0000000000000; ei[0] = 4'd1;
    ev[1] = 64'h3FF0000000000000; ei[1] = 4'd6;
    ev[2] = 64'h7FF8000000000000; ei[2] = 4'd9;
    send(10'h242, 2'b01);
    stream(3, 1);

    // Half: infinities and signalling NaN, boxed into 64 bits.
    ev[0] = 64'hFFFFFFFF_FFFFFC00; ei[0] = 4'd0;
    ev[1] = 64'hFFFFFFFF_FFFF7C00; ei[1] = 4'd7;
    ev[2] = 64'hFFFFFFFF_FFFF7C01; ei[2] = 4'd8;
    send(10'h181, 2'b10);
    stream(3, 0);

    // Empty mask.
    send(10'h000, 2'b00);
    check("empty_valid", 64'(OutValid), 64'd0);
    check("empty_ready", 64'(ReqReady), 64'd1);
    check("empty_busy", 64'(Busy), 64'd0);

    // Quad is unsupported in this configuration.
    send(10'h3FF, 2'b11);
    check("err_pulse", 64'(ReqErr), 64'd1);
    check("err_valid", 64'(OutValid), 64'd0);
    check("err_busy", 64'(Busy), 64'd0);
    @(negedge clk);
    check("err_drop", 64'(ReqErr), 64'd0);
    check("err_valid2", 64'(OutValid), 64'd0);

    // Reset after the second of five elements.
    send(10'h01F, 2'b00);
    check("pre_rst_idx0", 64'(OutIdx), 64'd0);
    @(negedge clk);
    check("pre_rst_idx1", 64'(OutIdx), 64'd1);
    @(negedge clk);
    check("pre_rst_idx2", 64'(OutIdx), 64'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(OutValid), 64'd0);
    check("mid_rst_busy", 64'(Busy), 64'd0);
    check("mid_rst_ready", 64'(ReqReady), 64'd1);
    check("mid_rst_val", OutVal, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ev[0] = 64'h8000000000000001; ei[0] = 4'd2;
    ev[1] = 64'h8000000000000000; ei[1] = 4'd3;
    send(10'h00C, 2'b01);
    stream(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
